lfsr_prng: RTL and testbench
============================

# lfsr_prng

Parametrised pseudo-random generator for the graphics pipeline, supplying random words to sprite-placement, dither and noise consumers. It generalises the single-step 32-bit LFSR with configurable width, tap polynomial, bits-advanced-per-clock, Fibonacci/Galois form, runtime reseed with zero-seed protection, and a post-seed warm-up phase. Values are delivered over a valid/ready handshake so each consumer gets a fresh word per transfer.

## Interface
- WIDTH, 32, state width in bits (4..64)
- TAPS, 32'h9010_2302, tap mask; bit i set = state bit i participates (default taps 31,28,20,13,9,8,1)
- STEPS, 1, single-bit shifts applied per advance (1..WIDTH)
- OUT_W, WIDTH, output word width (1..WIDTH)
- SEED_DEFAULT, 1, reset state and zero-seed substitute; must be nonzero
- WARMUP, 0, advances discarded after reset/load before output is valid (0..255)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global advance enable
- mode  in  1  0 = Fibonacci, 1 = Galois
- load  in  1  synchronous reseed strobe
- seed  in  WIDTH  reseed value, sampled when load=1
- out_valid  out  1  rand holds a fresh value
- out_ready  in  1  consumer accepts rand
- rand  out  OUT_W  state[OUT_W-1:0]

## Operation
- Single shift, Fibonacci: fb = XOR of state[i] where TAPS[i]=1; next = {state[WIDTH-2:0], fb}.
- Single shift, Galois: m = state[WIDTH-1]; next = {state[WIDTH-2:0], m} ^ ({WIDTH{m}} & (TAPS & ~1)). A nonzero state never maps to zero.
- An advance applies STEPS single shifts combinationally in one clock; mode is sampled at that clock edge.
- FSM states: WARM, RUN.
  - WARM: out_valid=0; each clock with en=1 advances the state and decrements warm_cnt; the advance that takes warm_cnt from 1 to 0 also moves the FSM to RUN.
  - RUN: out_valid=1; advance when en && out_ready; otherwise hold state.
- Load, highest priority, valid in any state: state <= (seed==0 ? SEED_DEFAULT : seed); warm_cnt <= WARMUP; FSM <= (WARMUP==0 ? RUN : WARM). Any simultaneous advance or handshake is discarded.
- en=0 freezes the state, warm_cnt and FSM. load still acts while en=0.
- mode changes take effect at the next advance. The state is not re-initialised.

## Timing
- Reset (async assert): state=SEED_DEFAULT, warm_cnt=WARMUP, FSM=(WARMUP==0 ? RUN : WARM), out_valid=(WARMUP==0), rand=SEED_DEFAULT[OUT_W-1:0].
- rand and out_valid are registered state. There is no combinational path from out_ready, load or en to them.
- Handshake: a transfer occurs on a clock edge where out_valid && out_ready && en. rand changes on that same edge.
- While out_valid=1 and no transfer occurs, rand is stable.
- After reset release or load, out_valid rises after exactly WARMUP clocks with en=1.
- load asserted in RUN: out_valid falls on that edge if WARMUP>0. If WARMUP=0, it stays high with rand=loaded seed.
- load asserted mid-WARM restarts the warm-up from the full count.
- Zero-seed substitution is the only path that corrects the all-zero state, since reset and load are the only writers besides advance.

## Test plan
- Defaults (WIDTH=32, STEPS=1, WARMUP=0, mode=0), en=1, out_ready=1 held from reset release -> rand = 0x00000001, 0x00000002, 0x00000005, 0x0000000A, 0x00000015 on successive cycles; out_valid=1 throughout.
- STEPS=4, otherwise defaults -> first transfer moves rand from 0x00000001 to 0x00000015; the bench checks 1000 advances against a 4x single-step reference model.
- mode=1, load seed=0x80000000, then one transfer -> rand = 0x90102303. A second check: load seed=1, transfer -> rand = 0x00000002.
- WARMUP=3: reset release -> out_valid low for 3 cycles, then high with rand=0x0000000A. Repeat with en dropped for 2 cycles mid-warm -> out_valid rises 2 cycles later with the same value.
- load seed=0 in RUN -> rand=0x00000001 next cycle. Then hold out_ready=0 for 10 cycles -> rand stable at 0x00000001; first ready cycle -> 0x00000002.
- Assert rst_n low mid-WARM with load=1 simultaneously -> outputs immediately at reset values. Load is ignored until rst_n returns high.

Source files
------------

// File: rtl/lfsr_prng_if.sv
// lfsr_prng_if: control, reseed and valid/ready output bundle for lfsr_prng.
interface lfsr_prng_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = WIDTH
);
  logic en;
  logic mode;
  logic load;
  logic [WIDTH-1:0] seed;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] rand_val;
  modport master (input en, mode, load, seed, out_ready, output out_valid, rand_val);
  modport slave (output en, mode, load, seed, out_ready, input out_valid, rand_val);
endinterface

// File: rtl/lfsr_prng.sv
// lfsr_prng: multi-step Fibonacci/Galois LFSR with reseed, warm-up and valid/ready delivery.
module lfsr_prng #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h9010_2302),
  parameter int STEPS = 1,
  parameter int OUT_W = WIDTH,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int WARMUP = 0
) (
  input logic clk,
  input logic rst_n,
  lfsr_prng_if.master bus
);
  typedef enum logic {WARM, RUN} st_t;
  localparam st_t ST_INIT = (WARMUP == 0) ? RUN : WARM;
  localparam logic [WIDTH-1:0] GMASK = TAPS & ~WIDTH'(1);
  st_t st, st_n;
  logic [WIDTH-1:0] state, state_n, stepped;
  logic [7:0] cnt, cnt_n;
  logic adv;
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s, input logic g);
    return g ? ({s[WIDTH-2:0], s[WIDTH-1]} ^ ({WIDTH{s[WIDTH-1]}} & GMASK))
             : {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction
  always_comb begin
    stepped = state;
    for (int i = 0; i < STEPS; i++) stepped = shift1(stepped, bus.mode);
  end
  assign adv = bus.en && (st == WARM || bus.out_ready);
  // load outranks any advance or handshake landing on the same edge
  always_comb begin
    st_n = st;
    state_n = state;
    cnt_n = cnt;
    if (bus.load) begin
      state_n = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
      cnt_n = 8'(WARMUP);
      st_n = ST_INIT;
    end else if (adv) begin
      state_n = stepped;
      if (st == WARM) begin
        cnt_n = cnt - 8'd1;
        st_n = (cnt == 8'd1) ? RUN : WARM;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_INIT;
      state <= SEED_DEFAULT;
      cnt <= 8'(WARMUP);
    end else begin
      st <= st_n;
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  assign bus.out_valid = (st == RUN);
  assign bus.rand_val = state[OUT_W-1:0];
endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed checks of default, 4-step and warm-up LFSR configurations.
module tb_lfsr_prng;
  logic clk = 0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] fib_exp [4] = '{32'h2, 32'h5, 32'hA, 32'h15};
  logic [31:0] m;
  logic [4:0] en_pat = 5'b11001;
  always #5 clk = ~clk;
  lfsr_prng_if #(.WIDTH(32)) d ();
  lfsr_prng_if #(.WIDTH(32)) s ();
  lfsr_prng_if #(.WIDTH(32)) w ();
  lfsr_prng u_def (.clk(clk), .rst_n(rst_n), .bus(d));
  lfsr_prng #(.STEPS(4)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(s));
  lfsr_prng #(.WARMUP(3)) u_w3 (.clk(clk), .rst_n(rst_n), .bus(w));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] fib1(input logic [31:0] v);
    return {v[30:0], ^(v & 32'h9010_2302)};
  endfunction
  initial begin
    rst_n = 0;
    {d.en, d.mode, d.load, d.out_ready, d.seed} = '0;
    {s.en, s.mode, s.load, s.out_ready, s.seed} = '0;
    {w.en, w.mode, w.load, w.out_ready, w.seed} = '0;
    repeat (2) step();
    chk("rst_def_rand", d.rand_val, 1);
    chk("rst_def_valid", d.out_valid, 1);
    chk("rst_w3_rand", w.rand_val, 1);
    chk("rst_w3_valid", w.out_valid, 0);
    d.en = 1; d.out_ready = 1; w.en = 1;
    rst_n = 1;
    chk("fib_init", d.rand_val, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fib_seq", d.rand_val, fib_exp[i]);
      chk("fib_valid", d.out_valid, 1);
      chk("warm_valid", w.out_valid, i >= 2);
    end
    chk("warm_rand", w.rand_val, 32'hA);
    w.load = 1; w.seed = 1;
    step();
    chk("w3_load_valid", w.out_valid, 0);
    chk("w3_load_rand", w.rand_val, 1);
    w.load = 0;
    for (int i = 0; i < 5; i++) begin
      w.en = en_pat[i];
      step();
      chk("warm_en_gap", w.out_valid, i == 4);
    end
    chk("warm_en_gap_rand", w.rand_val, 32'hA);
    w.load = 1;
    step();
    w.load = 0;
    step();
    w.load = 1;
    step();
    w.load = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("warm_restart", w.out_valid, i == 2);
    end
    chk("warm_restart_rand", w.rand_val, 32'hA);
    d.mode = 1; d.load = 1; d.seed = 32'h8000_0000;
    step();
    chk("gal_load", d.rand_val, 32'h8000_0000);
    d.load = 0;
    step();
    chk("gal_msb", d.rand_val, 32'h9010_2303);
    d.load = 1; d.seed = 1;
    step();
    d.load = 0;
    step();
    chk("gal_lsb", d.rand_val, 2);
    d.mode = 0; d.load = 1; d.seed = 0;
    step();
    chk("zero_seed", d.rand_val, 1);
    chk("zero_seed_valid", d.out_valid, 1);
    d.load = 0; d.out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_hold", d.rand_val, 1);
    end
    d.out_ready = 1;
    step();
    chk("stall_release", d.rand_val, 2);
    d.en = 0;
    step();
    chk("en_freeze", d.rand_val, 2);
    s.en = 1; s.out_ready = 1;
    m = 1;
    for (int i = 0; i < 1000; i++) begin
      m = fib1(fib1(fib1(fib1(m))));
      step();
      if (i == 0) chk("s4_first", s.rand_val, 32'h15);
      chk("s4_adv", s.rand_val, m);
    end
    w.en = 1; w.load = 1; w.seed = 32'h55;
    step();
    w.load = 0;
    step();
    rst_n = 0; w.load = 1; w.seed = 32'h77;
    #1;
    chk("arst_w3_rand", w.rand_val, 1);
    chk("arst_w3_valid", w.out_valid, 0);
    chk("arst_def_rand", d.rand_val, 1);
    chk("arst_s4_rand", s.rand_val, 1);
    repeat (2) step();
    chk("arst_load_ignored", w.rand_val, 1);
    w.load = 0;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_rewarm", w.out_valid, i == 2);
    end
    chk("arst_rewarm_rand", w.rand_val, 32'hA);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
